// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Round-robin arbiter that shares one WIDTH-bit adder-subtractor between two
//   requesters. Each accepted operation is computed in the same cycle and
//   registered, with carry and signed-overflow flags, into a single-entry
//   output buffer. That buffer is held until the consumer takes it. A new
//   operation may be accepted in the same cycle the held result is drained.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      requester handshake
//   req{0,1}_sub               0 = a + b, 1 = a - b
//   req{0,1}_a/_b              operands
//   res_valid/res_ready        result handshake
//   res_sum                    result modulo 2^WIDTH
//   res_cout                   carry out of the MSB (subtract: 1 = no borrow)
//   res_ovf                    two's-complement signed overflow
//   res_id                     index of the requester that issued the result
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             winner;
  logic             can_accept;
  logic             accept;
  logic             sel_sub;
  logic [WIDTH-1:0] sel_a, sel_b, b_eff, sum;
  logic             cout, ovf;

  // The buffer can take a new operation when it is empty or is being drained
  // on this same edge.
  assign can_accept = (state == EMPTY) || res_ready;

  // Arbitration: a lone requester wins outright; under contention the
  // requester that was not granted last wins. No lock is held across cycles.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // that no path leaves it unassigned and infers a latch.
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant;
    else if (req1_valid)          winner = 1'b1;
  end

  assign req0_ready = can_accept && (winner == 1'b0);
  assign req1_ready = can_accept && (winner == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Shared datapath: subtract is a + ~b + 1.
  assign sel_sub       = winner ? req1_sub : req0_sub;
  assign sel_a         = winner ? req1_a   : req0_a;
  assign sel_b         = winner ? req1_b   : req0_b;
  assign b_eff         = sel_b ^ {WIDTH{sel_sub}};
  assign {cout, sum}   = {1'b0, sel_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel_sub};
  // Overflow: both effective operands share a sign that the result does not.
  assign ovf           = (sel_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != sel_a[WIDTH-1]);

  always_comb begin
    state_next = state;
    if (accept)         state_next = FULL;
    else if (res_ready) state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) last_grant <= winner;
    end
  end

  // Result registers are cleared by reset so a discarded result never shows
  // up on the outputs. On a plain drain they keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
      res_id   <= 1'b0;
    end else if (accept) begin
      res_sum  <= sum;
      res_cout <= cout;
      res_ovf  <= ovf;
      res_id   <= winner;
    end
  end

  assign res_valid = (state == FULL);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (WIDTH = 4). A behavioural model
// computes results with plain integer arithmetic and tracks the arbitration
// rules. Directed scenarios come first, then a randomized run.
module tb_addsub_arbiter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req0_sub = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic         req1_valid = 1'b0, req1_sub = 1'b0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         res_ready = 1'b0;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_cout, res_ovf, res_id;
  logic [W-1:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic         m_full = 1'b0;
  logic         m_last = 1'b1;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_id = 1'b0;
  int           g_id;   // requester granted in the last cycle, -1 if none

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: unsigned and signed integer math, no bit tricks.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= MOD / 2) ? ua - MOD : ua;
    sb = (ub >= MOD / 2) ? ub - MOD : ub;
    if (sub) begin
      ur = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      ur = ua + ub; sr = sa + sb; c = (ur >= MOD);
    end
    s = W'((ur + MOD) % MOD);
    o = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
  endtask

  // One clock cycle: drive inputs just after an edge, check ready, advance the
  // model across the next edge, then check the registered outputs.
  task automatic cycle(input string name,
                       input logic v0, input logic s0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic s1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rr);
    logic can, w, acc;
    req0_valid = v0; req0_sub = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_sub = s1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
    #1;
    can = !m_full || rr;
    if (v0 && v1) w = !m_last;
    else          w = v1;
    acc = can && (v0 || v1);
    if (v0) begin
      n_checks++;
      if (req0_ready !== (can && !w)) begin
        n_fail++;
        $display("FAIL %s req0_ready got %b want %b", name, req0_ready, can && !w);
      end
    end
    if (v1) begin
      n_checks++;
      if (req1_ready !== (can && w)) begin
        n_fail++;
        $display("FAIL %s req1_ready got %b want %b", name, req1_ready, can && w);
      end
    end
    @(posedge clk);
    g_id = -1;
    if (acc) begin
      if (w) ref_op(a1, b1, s1, m_sum, m_cout, m_ovf);
      else   ref_op(a0, b0, s0, m_sum, m_cout, m_ovf);
      m_id = w; m_last = w; m_full = 1'b1; g_id = int'(w);
    end else if (rr) begin
      m_full = 1'b0;
    end
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {m_full, m_sum, m_cout, m_ovf, m_id}) begin
      n_fail++;
      $display("FAIL %s result got v=%b sum=%h c=%b o=%b id=%b want v=%b sum=%h c=%b o=%b id=%b",
               name, res_valid, res_sum, res_cout, res_ovf, res_id,
               m_full, m_sum, m_cout, m_ovf, m_id);
    end
  endtask

  task automatic idle(input logic rr);
    cycle("idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, rr);
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %b want 0", {res_valid, res_sum, res_cout, res_ovf, res_id});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    cycle("add_5_3", 1'b1, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if ({res_sum, res_cout, res_ovf, res_id} !== {4'h8, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_5_3_const got sum=%h c=%b o=%b id=%b want 8 0 1 0", res_sum, res_cout, res_ovf, res_id);
    end
    cycle("add_f_1", 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {4'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_f_1_const got sum=%h c=%b o=%b want 0 1 0", res_sum, res_cout, res_ovf);
    end
  endtask

  task automatic test_sub;
    cycle("sub_3_5", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd3, 4'd5, 1'b1);
    n_checks++;
    if ({res_sum, res_cout, res_ovf, res_id} !== {4'hE, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_3_5_const got sum=%h c=%b o=%b id=%b want e 0 0 1", res_sum, res_cout, res_ovf, res_id);
    end
    cycle("sub_7_8", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd7, 4'h8, 1'b1);
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {4'hF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_7_8_const got sum=%h c=%b o=%b want f 0 1", res_sum, res_cout, res_ovf);
    end
  endtask

  // Last grant is requester 1 here, so contention should alternate 0,1,0,1.
  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) begin
      cycle("round_robin", 1'b1, 1'b0, W'(i), 4'd1, 1'b1, 1'b1, 4'd9, W'(i), 1'b1);
      n_checks++;
      if (g_id != (i % 2) || res_id !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL round_robin_%0d grant got %0d id=%b want %0d", i, g_id, res_id, i % 2);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] held;
    idle(1'b1);
    cycle("bp_load", 1'b1, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0, '0, '0, 1'b0);
    held = res_sum;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 1'b1, 1'b1, 4'd6, 4'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
      n_checks++;
      if (res_sum !== held || req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got sum=%h r0=%b r1=%b v=%b want sum=%h r0=0 r1=0 v=1",
                 i, res_sum, req0_ready, req1_ready, res_valid, held);
      end
    end
    // Release: requester 1 wins (0 was granted last), buffer stays full.
    cycle("bp_release", 1'b1, 1'b1, 4'd6, 4'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 4'd6 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_const got v=%b sum=%h id=%b want 1 6 1", res_valid, res_sum, res_id);
    end
  endtask

  task automatic test_drain;
    cycle("drain_load", 1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(1'b1);
    n_checks++;
    if (res_valid !== 1'b0 || res_sum !== 4'd3) begin
      n_fail++;
      $display("FAIL drain_empty got v=%b sum=%h want v=0 sum=3", res_valid, res_sum);
    end
    // Empty buffer: each lone requester is ready even without res_ready.
    cycle("drain_r1", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd4, 4'd4, 1'b0);
    idle(1'b1);
    cycle("drain_r0", 1'b1, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1'b1);
  endtask

  task automatic test_reset_mid_op;
    cycle("rst_load", 1'b1, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_op got %b want 0", {res_valid, res_sum, res_cout, res_ovf, res_id});
    end
    m_full = 1'b0; m_last = 1'b1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("rst_after", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
    n_checks++;
    if (res_sum !== 4'h2 || res_id !== 1'b1 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after_const got sum=%h id=%b v=%b want 2 1 1", res_sum, res_id, res_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      cycle("random",
            1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_round_robin;
    test_backpressure;
    test_drain;
    test_reset_mid_op;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
